mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Shift-and-add multiply sequencer for the CPU datapath. On a start pulse from the
//  status counter's multiply path, it drives the multiplier datapath one step per cycle:
//  load, conditional add, shift. It exits early once the multiplier register is all zero,
//  then pulses done so the controller can resume. Moore FSM; no arithmetic in this block.
// PARAMETERS
//  WIDTH   8   operand width in bits; bounds the iteration count (hard limit)
//  CNT_W   4   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      synchronous, active-low; 0 at a rising edge -> IDLE
//  start        in   1      request a multiply; sampled only in IDLE
//  mplr_lsb     in   1      bit 0 of datapath multiplier register (current value)
//  is_all_zero  in   1      datapath multiplier register == 0 (current value)
//  ld_operands  out  1      load multiplicand/multiplier registers
//  clr_acc      out  1      clear product accumulator
//  add_en       out  1      acc <= acc + multiplicand
//  shift_en     out  1      shift multiplier right, multiplicand left
//  busy         out  1      1 in every state except IDLE
//  done         out  1      one-cycle completion pulse
//  state        out  3      encoded FSM state (debug/status)
//  iter_cnt     out  CNT_W  remaining iterations
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE, iter_cnt=0, all control outputs 0.
//    Applies from any state, including mid-ADD or mid-SHIFT. The datapath result is then
//    undefined, and done is not pulsed.
//  - State encoding: IDLE=0, LOAD=1, CHECK=2, ADD=3, SHIFT=4, DONE=5. Codes 6-7 -> IDLE.
//  - All outputs decode from the state register only (Moore). No input-to-output paths.
//  - IDLE: start=1 -> LOAD. Otherwise stay.
//  - LOAD: ld_operands=1, clr_acc=1, iter_cnt<=WIDTH; -> CHECK.
//  - CHECK: all control outputs 0. Exit to DONE if is_all_zero=1 or iter_cnt==0
//    (exit has priority). Otherwise mplr_lsb=1 -> ADD, else -> SHIFT.
//  - ADD: add_en=1; -> SHIFT.
//  - SHIFT: shift_en=1, iter_cnt<=iter_cnt-1 (never wraps below 0); -> CHECK.
//  - DONE: done=1 for exactly one cycle; -> IDLE. start is ignored in DONE.
//  - start while busy=1 is ignored and not queued. The controller holds or re-issues it.
//  - Datapath inputs (mplr_lsb, is_all_zero) reflect register contents after the
//    previous edge. The datapath must present them combinationally.
//  - Latency. Let the start edge be cycle 0, h = index of the highest set bit of the
//    multiplier, p = popcount, and k = h+1 (k=0 when the multiplier is 0).
//    LOAD is in cycle 1, and done is asserted in cycle 3 + 2k + p.
//  - If is_all_zero is stuck at 0, iter_cnt bounds the run to WIDTH shifts.
// TESTING
//  1. WIDTH=8, mplr=0x00: LOAD in cycle 1, CHECK in cycle 2, done in cycle 3. add_en and
//     shift_en never assert.
//  2. mplr=0x01: one ADD, one SHIFT, done in cycle 6. Next start is accepted the cycle
//     after done.
//  3. mplr=0x80: 8 shifts, 1 add, done in cycle 20. mplr=0xFF: 8 adds, 8 shifts, done in
//     cycle 27. iter_cnt ends at 0.
//  4. Pulse start in cycles 4 and 20 of a 0xFF run: no effect. Only one done pulse.
//  5. Drive reset=0 in an ADD cycle: next cycle state=IDLE, busy=0, all controls 0, no
//     done. A fresh start then runs normally.
//  6. Force is_all_zero=0 and mplr_lsb=0: exactly 8 SHIFT cycles, 0 adds, done in
//     cycle 19.

Source files
------------

// File: rtl/mul_sequencer.sv
// Shift-and-add multiply sequencer: steps an external multiplier datapath through
// load / conditional add / shift, exits early when the multiplier register empties.
module mul_sequencer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mplr_lsb,
   input  logic             is_all_zero,
   output logic             ld_operands,
   output logic             clr_acc,
   output logic             add_en,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t cur;
   state_t nxt;

   // Transition rule; exit from CHECK outranks the add/shift choice.
   function automatic state_t next_state(
      input state_t           s,
      input logic             go,
      input logic             lsb,
      input logic             zero,
      input logic [CNT_W-1:0] cnt
   );
      state_t n;
      n = IDLE;
      case (s)
         IDLE:    n = go ? LOAD : IDLE;
         LOAD:    n = CHECK;
         CHECK: begin
            if (zero || (cnt == '0))
               n = DONE;
            else if (lsb)
               n = ADD;
            else
               n = SHIFT;
         end
         ADD:     n = SHIFT;
         SHIFT:   n = CHECK;
         DONE:    n = IDLE;
         default: n = IDLE;
      endcase
      return n;
   endfunction

   assign nxt   = next_state(cur, start, mplr_lsb, is_all_zero, iter_cnt);
   assign state = cur;

   // Outputs are registered from the next state, so each one is a pure decode of cur.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cur         <= IDLE;
         iter_cnt    <= '0;
         ld_operands <= 1'b0;
         clr_acc     <= 1'b0;
         add_en      <= 1'b0;
         shift_en    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         cur         <= nxt;
         ld_operands <= (nxt == LOAD);
         clr_acc     <= (nxt == LOAD);
         add_en      <= (nxt == ADD);
         shift_en    <= (nxt == SHIFT);
         busy        <= (nxt != IDLE);
         done        <= (nxt == DONE);
         case (cur)
            LOAD:    iter_cnt <= CNT_W'(WIDTH);
            SHIFT: begin
               if (iter_cnt != '0)
                  iter_cnt <= iter_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: behavioural datapath, latency/count/product reference model
// and a done-driven scoreboard.
module tb_mul_sequencer;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             mplr_lsb;
   logic             is_all_zero;
   logic             ld_operands, clr_acc, add_en, shift_en, busy, done;
   logic [2:0]       state;
   logic [CNT_W-1:0] iter_cnt;

   always #5 clk = ~clk;

   mul_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .mplr_lsb(mplr_lsb),
      .is_all_zero(is_all_zero), .ld_operands(ld_operands), .clr_acc(clr_acc),
      .add_en(add_en), .shift_en(shift_en), .busy(busy), .done(done),
      .state(state), .iter_cnt(iter_cnt)
   );

   // Datapath under control of the sequencer
   logic [7:0]  op_a = '0, op_b = '0, mp = '0;
   logic [15:0] mc = '0, acc = '0;
   bit          stuck = 1'b0;

   always @(posedge clk) begin
      if (ld_operands) begin
         mc <= 16'(op_a);
         mp <= op_b;
      end else if (shift_en) begin
         mp <= mp >> 1;
         mc <= mc << 1;
      end
      if (clr_acc)
         acc <= '0;
      else if (add_en)
         acc <= acc + mc;
   end

   assign mplr_lsb    = stuck ? 1'b0 : mp[0];
   assign is_all_zero = stuck ? 1'b0 : (mp == 8'd0);

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int unsigned compared = 0;
   int unsigned mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int unsigned done_cyc;
      int unsigned adds;
      int unsigned shifts;
      int unsigned iter;
      logic [15:0] prod;
      bit          chk_prod;
   } exp_t;

   exp_t sb[$];

   bit          mon_en = 1'b0;
   int unsigned adds_seen = 0;
   int unsigned shifts_seen = 0;

   // Monitor: decode sanity every cycle, full scoreboard check on each done pulse
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("busy_decode", 32'(busy), 32'(state != 3'd0));
         if (ld_operands) begin
            adds_seen   = 0;
            shifts_seen = 0;
         end
         if (add_en)   adds_seen++;
         if (shift_en) shifts_seen++;
         if (done) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
               chk("add_count", 32'(adds_seen), 32'(e.adds));
               chk("shift_count", 32'(shifts_seen), 32'(e.shifts));
               chk("iter_at_done", 32'(iter_cnt), 32'(e.iter));
               if (e.chk_prod)
                  chk("product", 32'(acc), 32'(e.prod));
            end
         end
      end
   end

   // Issue one multiply and push its expected outcome from the latency formula.
   task automatic run(input logic [7:0] a, input logic [7:0] b, input bit stk,
                      output int unsigned e_edge);
      exp_t        e;
      int unsigned k, p, n;
      n = 0;
      @(negedge clk);
      while ((busy || done) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         compared++;
         mismatched++;
         $display("FAIL idle_timeout: got busy=%0d expected idle within 300 cycles", busy);
      end
      op_a  = a;
      op_b  = b;
      stuck = stk;
      start = 1'b1;
      @(posedge clk);
      #1;
      e_edge = cyc;
      start  = 1'b0;
      chk("load_state", 32'(state), 32'd1);
      chk("load_ctl", 32'({ld_operands, clr_acc, add_en, shift_en}), 32'(4'b1100));
      k = 0;
      for (int unsigned i = 0; i < 8; i++)
         if (b[i]) k = i + 1;
      p = 32'($countones(b));
      if (stk) begin
         k = WIDTH;
         p = 0;
      end
      e.done_cyc = e_edge + 2 + 2 * k + p;
      e.adds     = p;
      e.shifts   = k;
      e.iter     = WIDTH - k;
      e.prod     = 16'(a) * 16'(b);
      e.chk_prod = !stk;
      sb.push_back(e);
   endtask

   initial begin
      int unsigned e;
      int unsigned n;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_ctl", 32'({ld_operands, clr_acc, add_en, shift_en, busy, done}), 32'd0);
      chk("reset_iter", 32'(iter_cnt), 32'd0);
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;

      run(8'h9C, 8'h00, 1'b0, e);
      run(8'h5A, 8'h01, 1'b0, e);
      run(8'h5A, 8'h01, 1'b0, e);
      run(8'hE7, 8'h80, 1'b0, e);
      run(8'hFF, 8'hFF, 1'b0, e);

      // Starts inside a running multiply must be dropped
      run(8'hC3, 8'hFF, 1'b0, e);
      while (cyc < e + 3) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_on_ignored_start", 32'(busy), 32'd1);
      while (cyc < e + 19) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("state_on_ignored_start", 32'(state != 3'd1), 32'd1);

      // Datapath stuck non-zero: iteration counter alone ends the run
      run(8'h11, 8'h00, 1'b1, e);

      // Reset landing on an ADD cycle
      run(8'h37, 8'hB5, 1'b0, e);
      n = 0;
      @(negedge clk);
      while (!add_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("add_seen_before_reset", 32'(add_en), 32'd1);
      reset = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("midrun_reset_state", 32'(state), 32'd0);
      chk("midrun_reset_ctl", 32'({ld_operands, clr_acc, add_en, shift_en, busy, done}), 32'd0);
      chk("midrun_reset_iter", 32'(iter_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run(8'h37, 8'hB5, 1'b0, e);

      repeat (20) run(8'($urandom), 8'($urandom), 1'b0, e);

      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
